// File: rtl/stim_pkg.sv
// Shared encodings for the stimulus pattern generator.
// Mode codes and FSM state encoding.
package stim_pkg;

    localparam logic [1:0] MODE_STAGGER = 2'd0;
    localparam logic [1:0] MODE_BIN     = 2'd1;
    localparam logic [1:0] MODE_WALK    = 2'd2;
    localparam logic [1:0] MODE_GRAY    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stim_pattern_gen_tick_prescaler.sv
// Base-tick prescaler: counts STEP cycles and flags the terminal count.
// The pulse is qualified by hold so a paused terminal count is suppressed.
module tick_prescaler #(
    parameter int STEP = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic pulse
);

    localparam int SCW = (STEP > 1) ? $clog2(STEP) : 1;

    logic [SCW-1:0] r_cnt;
    logic           w_term;

    assign w_term = (r_cnt == SCW'(STEP - 1));
    assign pulse  = w_term && !hold && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (!hold) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stim_pattern_gen.sv
// Parametrised stimulus generator: N_CH channels stepped by a base tick,
// four pattern modes, pause, and a bounded run that ends in a sticky done.
module stim_pattern_gen
    import stim_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int STEP      = 10,
    parameter int MAX_TICKS = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic            pause,
    output logic [N_CH-1:0] pattern,
    output logic            tick,
    output logic            busy,
    output logic            done
);

    localparam int TCW = $clog2(MAX_TICKS + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_mode;
    logic [N_CH-1:0] r_pattern;
    logic [N_CH-1:0] w_pat_nxt;
    logic [N_CH-1:0] w_b;
    logic [TCW-1:0]  r_tick_cnt;
    logic [TCW-1:0]  w_k;
    logic [3:0]      r_mc [N_CH];
    logic            r_tick;
    logic            w_launch;
    logic            w_hold;
    logic            w_wrap;
    logic            w_last;

    assign w_launch = start && (r_state != S_RUN);
    assign w_hold   = (r_state != S_RUN) || pause;
    assign w_k      = r_tick_cnt + 1'b1;
    assign w_last   = (w_k == TCW'(MAX_TICKS));

    tick_prescaler #(
        .STEP (STEP)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clear (w_launch),
        .hold  (w_hold),
        .pulse (w_wrap)
    );

    // Low N_CH bits of the new tick count, zero-extended when TCW < N_CH
    for (genvar g = 0; g < N_CH; g++) begin : g_kbits
        if (g < TCW) begin : g_in
            assign w_b[g] = w_k[g];
        end else begin : g_out
            assign w_b[g] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_wrap && w_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pat_nxt = r_pattern;
        case (r_mode)
            MODE_STAGGER: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (r_mc[i] == 4'(i)) w_pat_nxt[i] = ~r_pattern[i];
                end
            end
            MODE_BIN:  w_pat_nxt = w_b;
            MODE_WALK: w_pat_nxt = (r_pattern << 1) | (r_pattern >> (N_CH - 1));
            MODE_GRAY: w_pat_nxt = w_b ^ (w_b >> 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_STAGGER;
            r_pattern  <= '0;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            for (int i = 0; i < N_CH; i++) r_mc[i] <= '0;
        end else if (w_launch) begin
            r_mode     <= mode;
            r_pattern  <= (mode == MODE_WALK) ? N_CH'(1) : '0;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            for (int i = 0; i < N_CH; i++) r_mc[i] <= '0;
        end else if (w_wrap) begin
            r_pattern  <= w_pat_nxt;
            r_tick_cnt <= w_k;
            r_tick     <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                r_mc[i] <= (r_mc[i] == 4'(i)) ? '0 : r_mc[i] + 1'b1;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign pattern = r_pattern;
    assign tick    = r_tick;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Scoreboarded bench for stim_pattern_gen (N_CH=4, STEP=2, MAX_TICKS=8),
// plus a single-channel instance for the walking-one corner.
module tb_stim_pattern_gen;

    localparam int NC = 4;
    localparam int ST = 2;
    localparam int MT = 8;

    typedef struct {
        logic [NC-1:0] pat;
        logic          dn;
        int            gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          pause = 1'b0;
    logic [NC-1:0] pattern;
    logic          tick, busy, done;

    logic          start1 = 1'b0;
    logic [0:0]    pattern1;
    logic          tick1, busy1, done1;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_tick = 0;

    logic [3:0] P_STAG [8] = '{4'b0001, 4'b0010, 4'b0111, 4'b1100,
                               4'b1101, 4'b1010, 4'b1011, 4'b0000};
    logic [3:0] P_BIN  [8] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100,
                               4'b0101, 4'b0110, 4'b0111, 4'b1000};
    logic [3:0] P_GRAY [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100};
    logic [3:0] P_WALK [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         G_PAUSE [8] = '{0, 2, 9, 3, 2, 2, 2, 2};

    stim_pattern_gen #(
        .N_CH      (NC),
        .STEP      (ST),
        .MAX_TICKS (MT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .pause   (pause),
        .pattern (pattern),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    stim_pattern_gen #(
        .N_CH      (1),
        .STEP      (ST),
        .MAX_TICKS (MT)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .mode    (2'd2),
        .pause   (1'b0),
        .pattern (pattern1),
        .tick    (tick1),
        .busy    (busy1),
        .done    (done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tick pulse pops one expectation
    always @(negedge clk) begin
        if (tick) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_tick: pattern=%b, none expected", pattern);
            end else begin
                e = q.pop_front();
                if (pattern !== e.pat || done !== e.dn) begin
                    n_err++;
                    $display("FAIL tick_pattern: got %b done=%b, expected %b done=%b",
                             pattern, done, e.pat, e.dn);
                end else if (e.gap != 0 && (cyc - last_tick) != e.gap) begin
                    n_err++;
                    $display("FAIL tick_gap: got %0d cycles, expected %0d",
                             cyc - last_tick, e.gap);
                end
            end
            last_tick = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] p, input logic dn, input int gap);
        exp_t e;
        e.pat = p;
        e.dn  = dn;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic push_run(input logic [3:0] pats [8], input int gaps [8], input int n);
        for (int i = 0; i < n; i++) push(pats[i], (i == MT - 1), gaps[i]);
    endtask

    task automatic launch(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 60) begin
            step(1);
            k++;
        end
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        step(1);
        chk({nm, "_drained"}, q.size(), 32'd0);
    endtask

    int g2 [8] = '{0, 2, 2, 2, 2, 2, 2, 2};

    initial begin
        step(3);
        rst = 1'b0;
        chk("rst_pattern", {28'd0, pattern}, 32'h0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        step(10);
        chk("idle_pattern", {28'd0, pattern}, 32'h0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Staggered toggle full run
        push_run(P_STAG, g2, 8);
        launch(2'd0);
        chk("stag_busy", {31'd0, busy}, 32'd1);
        wait_done("stag");
        step(5);
        chk("stag_frozen", {28'd0, pattern}, 32'h0);
        chk("stag_sticky", {31'd0, done}, 32'd1);

        // Binary with a 7-cycle pause and a pause on the terminal count
        push_run(P_BIN, G_PAUSE, 8);
        launch(2'd1);
        chk("bin_restart_done", {31'd0, done}, 32'd0);
        step(4);
        pause = 1'b1;
        step(4);
        chk("pause_tick", {31'd0, tick}, 32'd0);
        chk("pause_pattern", {28'd0, pattern}, 32'h2);
        step(3);
        pause = 1'b0;
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        wait_done("bin");
        chk("bin_final", {28'd0, pattern}, 32'h8);

        // Gray with start and mode change mid-run (both ignored)
        push_run(P_GRAY, g2, 8);
        launch(2'd3);
        step(3);
        start = 1'b1;
        mode  = 2'd1;
        step(2);
        start = 1'b0;
        wait_done("gray");

        // Walking one, restarted from DONE
        push_run(P_WALK, g2, 8);
        launch(2'd2);
        chk("walk_init", {28'd0, pattern}, 32'h1);
        chk("walk_done_clr", {31'd0, done}, 32'd0);
        wait_done("walk");

        // Mode 0 restart from DONE, then reset at tick 5
        push_run(P_STAG, g2, 5);
        launch(2'd0);
        chk("restart_pattern", {28'd0, pattern}, 32'h0);
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        step(10);
        chk("t5_pattern", {28'd0, pattern}, 32'hD);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_pattern", {28'd0, pattern}, 32'h0);
        chk("midrst_tick", {31'd0, tick}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        step(6);
        chk("midrst_drained", q.size(), 32'd0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);

        // Single channel walking one stays at 1
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("walk1_pattern", {31'd0, pattern1}, 32'd1);
            step(1);
        end
        chk("walk1_done", {31'd0, done1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
